// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice: all five channels fully registered (valid/data and ready).
// Define AXIL_REG_SLICE_FULL_EN for a two-entry skid buffer per channel (full throughput).
module axil_reg_slice #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // Slave side (from master)
  input  logic [ADDR_WIDTH-1:0]   s_awAddr,
  input  logic [2:0]              s_awProt,
  input  logic                    s_awValid,
  output logic                    s_awReady,
  input  logic [DATA_WIDTH-1:0]   s_wData,
  input  logic [DATA_WIDTH/8-1:0] s_wStrb,
  input  logic                    s_wValid,
  output logic                    s_wReady,
  output logic [1:0]              s_bResp,
  output logic                    s_bValid,
  input  logic                    s_bReady,
  input  logic [ADDR_WIDTH-1:0]   s_arAddr,
  input  logic [2:0]              s_arProt,
  input  logic                    s_arValid,
  output logic                    s_arReady,
  output logic [DATA_WIDTH-1:0]   s_rData,
  output logic [1:0]              s_rResp,
  output logic                    s_rValid,
  input  logic                    s_rReady,
  // Master side (to CSR)
  output logic [ADDR_WIDTH-1:0]   m_awAddr,
  output logic [2:0]              m_awProt,
  output logic                    m_awValid,
  input  logic                    m_awReady,
  output logic [DATA_WIDTH-1:0]   m_wData,
  output logic [DATA_WIDTH/8-1:0] m_wStrb,
  output logic                    m_wValid,
  input  logic                    m_wReady,
  input  logic [1:0]              m_bResp,
  input  logic                    m_bValid,
  output logic                    m_bReady,
  output logic [ADDR_WIDTH-1:0]   m_arAddr,
  output logic [2:0]              m_arProt,
  output logic                    m_arValid,
  input  logic                    m_arReady,
  input  logic [DATA_WIDTH-1:0]   m_rData,
  input  logic [1:0]              m_rResp,
  input  logic                    m_rValid,
  output logic                    m_rReady
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned NumCh = 5;
  localparam int unsigned AxW   = ADDR_WIDTH + 3;
  localparam int unsigned WW    = DATA_WIDTH + StrbW;
  localparam int unsigned BW    = 2;
  localparam int unsigned RW    = DATA_WIDTH + 2;
  localparam int unsigned TotW  = 2 * AxW + WW + BW + RW;

  // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R; payloads packed LSB-first in that order.
  function automatic int unsigned ch_w(input int unsigned c);
    case (c)
      0, 3:    return AxW;
      1:       return WW;
      2:       return BW;
      default: return RW;
    endcase
  endfunction

  function automatic int unsigned ch_off(input int unsigned c);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < c; i++) off += ch_w(i);
    return off;
  endfunction

  logic [NumCh-1:0] w_up_vld, w_up_rdy, w_dn_vld, w_dn_rdy;
  logic [TotW-1:0]  w_up_data, w_dn_data;

  assign w_up_vld  = {m_rValid, s_arValid, m_bValid, s_wValid, s_awValid};
  assign w_dn_rdy  = {s_rReady, m_arReady, s_bReady, m_wReady, m_awReady};
  assign w_up_data = {m_rData, m_rResp, s_arAddr, s_arProt, m_bResp,
                      s_wData, s_wStrb, s_awAddr, s_awProt};

  assign {m_rReady, s_arReady, m_bReady, s_wReady, s_awReady} = w_up_rdy;
  assign {s_rValid, m_arValid, s_bValid, m_wValid, m_awValid} = w_dn_vld;
  assign {s_rData, s_rResp, m_arAddr, m_arProt, s_bResp,
          m_wData, m_wStrb, m_awAddr, m_awProt} = w_dn_data;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    localparam int unsigned W   = ch_w(c);
    localparam int unsigned Off = ch_off(c);

    logic         w_up_hs, w_dn_hs;
    logic         r_up_rdy, r_dn_vld;
    logic [W-1:0] r_main;

    assign w_up_hs = w_up_vld[c] & r_up_rdy;
    assign w_dn_hs = r_dn_vld & w_dn_rdy[c];

`ifdef AXIL_REG_SLICE_FULL_EN
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;
    state_e       r_state;
    logic [W-1:0] r_skid;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_state  <= StEmpty;
        r_up_rdy <= 1'b0;
        r_dn_vld <= 1'b0;
        r_main   <= '0;
        r_skid   <= '0;
      end else begin
        case (r_state)
          StEmpty: begin
            r_up_rdy <= 1'b1;
            if (w_up_hs) begin
              r_main   <= w_up_data[Off +: W];
              r_dn_vld <= 1'b1;
              r_state  <= StOne;
            end
          end
          StOne: begin
            if (w_up_hs && w_dn_hs) begin
              r_main <= w_up_data[Off +: W];
            end else if (w_up_hs) begin
              r_skid   <= w_up_data[Off +: W];
              r_up_rdy <= 1'b0;
              r_state  <= StFull;
            end else if (w_dn_hs) begin
              r_dn_vld <= 1'b0;
              r_state  <= StEmpty;
            end
          end
          StFull: begin
            if (w_dn_hs) begin
              r_main   <= r_skid;
              r_up_rdy <= 1'b1;
              r_state  <= StOne;
            end
          end
          default: r_state <= StEmpty;
        endcase
      end
    end
`else
    // Ready is the registered complement of valid, so capture and drain alternate.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_up_rdy <= 1'b0;
        r_dn_vld <= 1'b0;
        r_main   <= '0;
      end else if (r_dn_vld) begin
        if (w_dn_hs) begin
          r_dn_vld <= 1'b0;
          r_up_rdy <= 1'b1;
        end
      end else if (w_up_hs) begin
        r_main   <= w_up_data[Off +: W];
        r_dn_vld <= 1'b1;
        r_up_rdy <= 1'b0;
      end else begin
        r_up_rdy <= 1'b1;
      end
    end
`endif

    assign w_up_rdy[c]          = r_up_rdy;
    assign w_dn_vld[c]          = r_dn_vld;
    assign w_dn_data[Off +: W]  = r_main;
  end

endmodule
